// File: rtl/ascon_perm_seq_dom.sv
// Round sequencer and two-share state register for the masked ASCON permutation.
// Shares stay in separate registers; each round consumes one fresh randomness word.
module ascon_perm_seq_dom #(
  parameter int RND_LAT    = 2,
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_rounds,
  input  logic [319:0] in_sh0,
  input  logic [319:0] in_sh1,
  input  logic         rnd_valid,
  input  logic [319:0] rnd_in,
  output logic         rnd_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_sh0,
  output logic [319:0] out_sh1,
  output logic         busy,
  output logic         dp_passthrough_en,
  output logic [319:0] dp_randbits,
  output logic [1:0]   dp_rcmode,
  output logic [3:0]   dp_constti,
  output logic [319:0] dp_xi_sh0,
  output logic [319:0] dp_xi_sh1,
  input  logic [319:0] dp_xo_sh0,
  input  logic [319:0] dp_xo_sh1
);

  localparam logic [3:0] LP_MAXR = 4'(MAX_ROUNDS);
  localparam logic [2:0] LP_LAT  = 3'(RND_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [319:0] r_sh0;
  logic [319:0] r_sh1;
  logic [319:0] r_rnd;
  logic [3:0]   r_rounds;
  logic [3:0]   r_rcnt;
  logic [2:0]   r_wcnt;

  logic [319:0] w_sh0_nxt;
  logic [319:0] w_sh1_nxt;
  logic [319:0] w_rnd_nxt;
  logic [3:0]   w_rounds_nxt;
  logic [3:0]   w_rcnt_nxt;
  logic [2:0]   w_wcnt_nxt;
  logic [3:0]   w_rclamp;
  logic [3:0]   w_rcnt_inc;

  assign w_rclamp   = (in_rounds > LP_MAXR) ? LP_MAXR : in_rounds;
  assign w_rcnt_inc = r_rcnt + 4'd1;

  assign dp_xi_sh0   = r_sh0;
  assign dp_xi_sh1   = r_sh1;
  assign out_sh0     = r_sh0;
  assign out_sh1     = r_sh1;
  assign dp_randbits = r_rnd;

  // FSM state register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Share, randomness and counter registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_sh0    <= '0;
      r_sh1    <= '0;
      r_rnd    <= '0;
      r_rounds <= '0;
      r_rcnt   <= '0;
      r_wcnt   <= '0;
    end else begin
      r_sh0    <= w_sh0_nxt;
      r_sh1    <= w_sh1_nxt;
      r_rnd    <= w_rnd_nxt;
      r_rounds <= w_rounds_nxt;
      r_rcnt   <= w_rcnt_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  // Next-state, register updates and datapath controls
  always_comb begin
    w_state_nxt       = r_state;
    w_sh0_nxt         = r_sh0;
    w_sh1_nxt         = r_sh1;
    w_rnd_nxt         = r_rnd;
    w_rounds_nxt      = r_rounds;
    w_rcnt_nxt        = r_rcnt;
    w_wcnt_nxt        = r_wcnt;
    in_ready          = 1'b0;
    rnd_ready         = 1'b0;
    out_valid         = 1'b0;
    busy              = 1'b1;
    dp_passthrough_en = 1'b0;
    dp_rcmode         = 2'b00;
    dp_constti        = 4'd0;
    unique case (r_state)
      S_IDLE: begin
        in_ready          = 1'b1;
        busy              = 1'b0;
        dp_passthrough_en = 1'b1;
        if (in_valid) begin
          w_sh0_nxt    = in_sh0;
          w_sh1_nxt    = in_sh1;
          w_rounds_nxt = w_rclamp;
          w_rcnt_nxt   = 4'd0;
          dp_rcmode    = 2'b01;
          dp_constti   = LP_MAXR - w_rclamp;
          w_state_nxt  = (w_rclamp == 4'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rnd_valid) begin
          rnd_ready   = 1'b1;
          w_rnd_nxt   = rnd_in;
          w_wcnt_nxt  = LP_LAT;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_wcnt_nxt = r_wcnt - 3'd1;
        if (r_wcnt == 3'd1) begin
          w_sh0_nxt   = dp_xo_sh0;
          w_sh1_nxt   = dp_xo_sh1;
          dp_rcmode   = 2'b10;
          w_rcnt_nxt  = w_rcnt_inc;
          w_state_nxt = (w_rcnt_inc == r_rounds) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        out_valid         = 1'b1;
        dp_passthrough_en = 1'b1;
        if (out_ready) begin
          w_sh0_nxt   = '0;
          w_sh1_nxt   = '0;
          w_rnd_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_perm_seq_dom.sv
// Bench for the masked ASCON round sequencer with a behavioural datapath.
// Results are checked against a plain unmasked ASCON permutation.
module tb_ascon_perm_seq_dom;

  localparam int LAT = 2;

  logic         clk;
  logic         nRST;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_rounds;
  logic [319:0] in_sh0;
  logic [319:0] in_sh1;
  logic         rnd_valid;
  logic [319:0] rnd_in;
  logic         rnd_ready;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_sh0;
  logic [319:0] out_sh1;
  logic         busy;
  logic         dp_passthrough_en;
  logic [319:0] dp_randbits;
  logic [1:0]   dp_rcmode;
  logic [3:0]   dp_constti;
  logic [319:0] dp_xi_sh0;
  logic [319:0] dp_xi_sh1;
  logic [319:0] dp_xo_sh0;
  logic [319:0] dp_xo_sh1;

  int total = 0;
  int bad   = 0;

  ascon_perm_seq_dom #(.RND_LAT(LAT), .MAX_ROUNDS(12)) dut (
    .clk(clk), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rounds(in_rounds), .in_sh0(in_sh0), .in_sh1(in_sh1),
    .rnd_valid(rnd_valid), .rnd_in(rnd_in), .rnd_ready(rnd_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sh0(out_sh0), .out_sh1(out_sh1), .busy(busy),
    .dp_passthrough_en(dp_passthrough_en),
    .dp_randbits(dp_randbits), .dp_rcmode(dp_rcmode),
    .dp_constti(dp_constti),
    .dp_xi_sh0(dp_xi_sh0), .dp_xi_sh1(dp_xi_sh1),
    .dp_xo_sh0(dp_xo_sh0), .dp_xo_sh1(dp_xo_sh1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128];
    x3 = s[127:64];  x4 = s[63:0];
    x2 = x2 ^ 64'(((15 - i) << 4) | i);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
    t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] ascon_perm(input logic [319:0] s, input int n);
    logic [319:0] v;
    v = s;
    for (int k = 12 - n; k < 12; k++) v = ascon_round(v, k);
    return v;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Datapath model: round-constant index plus a remasked unmasked round
  logic [3:0] m_rcidx;
  always @(posedge clk or negedge nRST) begin
    if (!nRST) m_rcidx <= 4'd0;
    else if (dp_rcmode == 2'b01) m_rcidx <= dp_constti;
    else if (dp_rcmode == 2'b10) m_rcidx <= m_rcidx + 4'd1;
  end

  always_comb begin
    dp_xo_sh0 = ascon_round(dp_xi_sh0 ^ dp_xi_sh1, int'(m_rcidx)) ^ dp_randbits;
    dp_xo_sh1 = dp_randbits;
  end

  task automatic chk(input string tag, input logic [319:0] obs,
                     input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [319:0] s0, input logic [319:0] s1,
                        input logic [3:0] r, input int stall_rnd,
                        input int stall_len, input int hold, input string tag);
    int er, cyc, pulses, advs, left;
    logic ok, hok, done, prev_cap;
    logic [319:0] last_rnd, pxi0, pxi1, h0, h1;
    er = (r > 4'd12) ? 12 : int'(r);
    @(negedge clk);
    in_valid = 1'b1; in_sh0 = s0; in_sh1 = s1; in_rounds = r;
    rnd_valid = 1'b1; rnd_in = rand320(); out_ready = 1'b0;
    #1;
    chk({tag, "_acc_ready"}, 320'(in_ready), 320'(1));
    chk({tag, "_acc_rcmode"}, 320'(dp_rcmode), 320'(2'b01));
    chk({tag, "_acc_constti"}, 320'(dp_constti), 320'(12 - er));
    @(negedge clk);
    in_valid = 1'b0; in_sh0 = rand320(); in_sh1 = rand320();
    in_rounds = 4'($urandom);
    cyc = 1; pulses = 0; advs = 0; left = stall_len;
    ok = 1'b1; done = 1'b0; prev_cap = 1'b1;
    last_rnd = '0; pxi0 = '0; pxi1 = '0;
    while (!done && cyc < 300) begin
      if (left > 0 && advs == stall_rnd - 1 && pulses == advs) begin
        rnd_valid = 1'b0; left--;
      end else begin
        rnd_valid = 1'b1;
      end
      rnd_in = rand320();
      #1;
      if (out_valid) begin
        done = 1'b1;
      end else begin
        if (!prev_cap && (dp_xi_sh0 !== pxi0 || dp_xi_sh1 !== pxi1)) ok = 1'b0;
        if (pulses > 0 && dp_randbits !== last_rnd) ok = 1'b0;
        if (dp_passthrough_en !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        if (in_ready !== 1'b0 || dp_rcmode === 2'b01) ok = 1'b0;
        if (rnd_ready) begin
          if (!rnd_valid) ok = 1'b0;
          pulses++;
          last_rnd = rnd_in;
        end
        prev_cap = (dp_rcmode == 2'b10);
        if (dp_rcmode == 2'b10) advs++;
        pxi0 = dp_xi_sh0; pxi1 = dp_xi_sh1;
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 320'(done), 320'(1));
    chk({tag, "_latency"}, 320'(cyc), 320'(er * (LAT + 1) + 1 + stall_len));
    chk({tag, "_rnd_pulses"}, 320'(pulses), 320'(er));
    chk({tag, "_rc_adv"}, 320'(advs), 320'(er));
    chk({tag, "_stable"}, 320'(ok), 320'(1));
    chk({tag, "_result"}, out_sh0 ^ out_sh1, ascon_perm(s0 ^ s1, er));
    if (er == 0) begin
      chk({tag, "_pass_sh0"}, out_sh0, s0);
      chk({tag, "_pass_sh1"}, out_sh1, s1);
    end
    chk({tag, "_done_ctl"},
        320'({dp_passthrough_en, busy, in_ready, rnd_ready}), 320'(4'b1100));
    h0 = out_sh0; h1 = out_sh1; hok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      rnd_valid = 1'($urandom); rnd_in = rand320();
      #1;
      if (out_valid !== 1'b1 || out_sh0 !== h0 || out_sh1 !== h1) hok = 1'b0;
      if (rnd_ready !== 1'b0 || dp_rcmode !== 2'b00) hok = 1'b0;
    end
    chk({tag, "_hold"}, 320'(hok), 320'(1));
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_rounds = 4'd12;
    in_sh0 = rand320(); in_sh1 = rand320();
    #1;
    chk({tag, "_hs_no_accept"},
        320'({in_ready, dp_rcmode}), 320'(3'b000));
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk({tag, "_clr_sh0"}, out_sh0, 320'(0));
    chk({tag, "_clr_sh1"}, out_sh1, 320'(0));
    chk({tag, "_clr_rnd"}, dp_randbits, 320'(0));
    chk({tag, "_idle_ctl"},
        320'({in_ready, busy, out_valid, dp_rcmode}), 320'(5'b10001));
    in_valid = 1'b0;
  endtask

  task automatic abort_test();
    int cyc, pulses, advs;
    logic found, never;
    @(negedge clk);
    in_valid = 1'b1; in_sh0 = rand320(); in_sh1 = rand320();
    in_rounds = 4'd12; rnd_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0; pulses = 0; advs = 0; found = 1'b0;
    while (!found && cyc < 100) begin
      rnd_in = rand320();
      #1;
      if (advs == 2 && pulses == 3 && !rnd_ready && dp_rcmode == 2'b00) begin
        found = 1'b1;
      end else begin
        if (rnd_ready) pulses++;
        if (dp_rcmode == 2'b10) advs++;
        @(negedge clk);
        cyc++;
      end
    end
    chk("abort_reach_wait3", 320'(found), 320'(1));
    #1 nRST = 1'b0;
    #1;
    chk("abort_idle", 320'({in_ready, busy, out_valid}), 320'(3'b100));
    chk("abort_sh0", out_sh0, 320'(0));
    chk("abort_rnd", dp_randbits, 320'(0));
    @(negedge clk);
    nRST = 1'b1;
    never = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) never = 1'b0;
    end
    chk("abort_no_output", 320'(never), 320'(1));
  endtask

  logic [319:0] a0, a1;
  logic rst_ok;

  initial begin
    nRST = 1'b0; in_valid = 1'b0; in_rounds = 4'd0;
    in_sh0 = '0; in_sh1 = '0; rnd_valid = 1'b0; rnd_in = '0;
    out_ready = 1'b0;
    rst_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rnd_valid = 1'($urandom); rnd_in = rand320();
      out_ready = 1'($urandom); in_sh0 = rand320(); in_sh1 = rand320();
      in_rounds = 4'($urandom);
      #1;
      if (out_sh0 !== '0 || out_sh1 !== '0 || dp_randbits !== '0) rst_ok = 1'b0;
      if (rnd_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) rst_ok = 1'b0;
      if (dp_rcmode !== 2'b00 || dp_constti !== 4'd0) rst_ok = 1'b0;
      if (in_ready !== 1'b1) rst_ok = 1'b0;
    end
    chk("reset_outputs", 320'(rst_ok), 320'(1));
    chk("reset_xi0", dp_xi_sh0, 320'(0));
    chk("reset_in_ready", 320'(in_ready), 320'(1));
    @(negedge clk);
    nRST = 1'b1; out_ready = 1'b0;

    run_op(rand320(), rand320(), 4'd12, 0, 0, 0, "p12");
    run_op('0, '0, 4'd6, 0, 0, 3, "p6zero");
    a0 = rand320(); a1 = rand320();
    run_op(a0, a1, 4'd8, 2, 5, 10, "stall");
    run_op(a0, a1, 4'd8, 0, 0, 0, "nostall");
    run_op(rand320(), rand320(), 4'd0, 0, 0, 2, "r0");
    run_op(rand320(), rand320(), 4'd15, 0, 0, 0, "r15");
    abort_test();
    run_op(rand320(), rand320(), 4'd12, 3, 4, 1, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
